// File: rtl/axi_hp_write_responder.sv
// -----------------------------------------------------------------------------
// axi_hp_write_responder
//
// AXI4 write-channel slave that stands in for the Zynq HP port in PL-only
// simulation and loopback builds. It accepts one 64-bit address/data burst
// at a time into a byte-enabled RAM and returns a B response. A registered
// readback port exposes the captured words.
//
// Parameters
//   MEM_ADDR_WIDTH  log2 of RAM depth in 64-bit words
//   BASE_ADDR       byte address of RAM word 0 (8-byte aligned)
//
// Ports
//   axi_aclk, axi_areset           clock, asynchronous active-high reset
//   s_axi_aw*                      write address channel (awprot/awcache unused)
//   s_axi_w*                       write data channel
//   s_axi_b*                       write response channel
//   rd_addr / rd_data              word readback, one cycle latency, read-first
//   burst_count                    completed B handshakes (wrapping)
//   err_count                      non-OKAY responses (saturating)
//
// Optional build macro
//   AXI_HP_WR_LAST_CHECK_EN        when defined, a wlast that does not match
//                                  the final beat forces SLVERR; otherwise
//                                  wlast is ignored.
// -----------------------------------------------------------------------------
module axi_hp_write_responder #(
  parameter int          MEM_ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
  input  logic                      axi_aclk,
  input  logic                      axi_areset,
  input  logic [31:0]               s_axi_awaddr,
  input  logic [3:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic [2:0]                s_axi_awprot,
  input  logic [3:0]                s_axi_awcache,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [63:0]               s_axi_wdata,
  input  logic [7:0]                s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [MEM_ADDR_WIDTH-1:0] rd_addr,
  output logic [63:0]               rd_data,
  output logic [31:0]               burst_count,
  output logic [15:0]               err_count
);

  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [1:0]  state_q, state_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [31:0] addr_q, addr_d;        // current beat byte address, 8-byte aligned
  logic [3:0]  len_q, len_d;
  logic [3:0]  beat_q, beat_d;
  logic        incr_q, incr_d;
  logic        illegal_q, illegal_d;  // bad awsize/awburst: suppress all writes
  logic        slverr_q, slverr_d;    // sticky SLVERR for this burst
  logic        decerr_q, decerr_d;    // sticky DECERR for this burst
  logic [31:0] burst_count_q, burst_count_d;
  logic [15:0] err_count_q, err_count_d;
  logic [63:0] rd_data_q;

  logic        aw_fire;
  logic        beat_fire;
  logic        aw_legal;
  logic        last_beat;
  logic        wlast_err;
  logic [31:0] beat_off;
  logic        beat_in_range;
  logic        mem_we;
  logic [MEM_ADDR_WIDTH-1:0] mem_idx;
  logic [7:0]  byte_we;
  logic        unused_ok;

  logic [63:0] mem [DEPTH];

  assign aw_fire   = awready_q && s_axi_awvalid;
  assign beat_fire = wready_q && s_axi_wvalid;
  assign aw_legal  = (s_axi_awsize == 3'b011) &&
                     ((s_axi_awburst == 2'b00) || (s_axi_awburst == 2'b01));
  assign last_beat = (beat_q == len_q);

  // Range check is done on the full 32-bit offset: an address below the base
  // wraps to a huge offset and therefore also fails the upper-bound test.
  assign beat_off      = addr_q - BASE_ADDR;
  assign beat_in_range = (addr_q >= BASE_ADDR) &&
                         ((beat_off[31:3] >> MEM_ADDR_WIDTH) == '0);
  assign mem_idx       = beat_off[MEM_ADDR_WIDTH+2:3];
  assign mem_we        = beat_fire && !illegal_q && beat_in_range;

`ifdef AXI_HP_WR_LAST_CHECK_EN
  assign wlast_err = (s_axi_wlast != last_beat);
  assign unused_ok = ^{s_axi_awprot, s_axi_awcache, s_axi_awaddr[2:0], beat_off[2:0]};
`else
  assign wlast_err = 1'b0;
  assign unused_ok = ^{s_axi_awprot, s_axi_awcache, s_axi_awaddr[2:0], beat_off[2:0],
                       s_axi_wlast};
`endif

  always_comb begin
    state_d       = state_q;
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    addr_d        = addr_q;
    len_d         = len_q;
    beat_d        = beat_q;
    incr_d        = incr_q;
    illegal_d     = illegal_q;
    slverr_d      = slverr_q;
    decerr_d      = decerr_q;
    burst_count_d = burst_count_q;
    err_count_d   = err_count_q;

    case (state_q)
      ST_IDLE: begin
        if (aw_fire) begin
          addr_d    = {s_axi_awaddr[31:3], 3'b000};
          len_d     = s_axi_awlen;
          incr_d    = (s_axi_awburst == 2'b01);
          illegal_d = !aw_legal;
          slverr_d  = !aw_legal;
          decerr_d  = 1'b0;
          beat_d    = 4'd0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat_fire) begin
          if (incr_q) begin
            addr_d = addr_q + 32'd8;
          end
          if (!beat_in_range) begin
            decerr_d = 1'b1;
          end
          if (wlast_err) begin
            slverr_d = 1'b1;
          end
          beat_d = beat_q + 4'd1;
          if (last_beat) begin
            // Fold in the final beat's own status, which is not yet in the
            // sticky flags.
            state_d  = ST_RESP;
            bvalid_d = 1'b1;
            if (slverr_q || wlast_err) begin
              bresp_d = RESP_SLVERR;
            end else if (decerr_q || !beat_in_range) begin
              bresp_d = RESP_DECERR;
            end else begin
              bresp_d = RESP_OKAY;
            end
          end
        end
      end
      ST_RESP: begin
        if (s_axi_bready) begin
          bvalid_d      = 1'b0;
          bresp_d       = RESP_OKAY;
          burst_count_d = burst_count_q + 32'd1;
          if ((bresp_q != RESP_OKAY) && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
          end
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        bvalid_d = 1'b0;
        bresp_d  = RESP_OKAY;
      end
    endcase
  end

  // Ready flags are registered views of the next state, so awready rises the
  // cycle after reset release or after the B handshake.
  assign awready_d = (state_d == ST_IDLE);
  assign wready_d  = (state_d == ST_DATA);

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q       <= ST_IDLE;
      awready_q     <= 1'b0;
      wready_q      <= 1'b0;
      bvalid_q      <= 1'b0;
      bresp_q       <= RESP_OKAY;
      addr_q        <= 32'd0;
      len_q         <= 4'd0;
      beat_q        <= 4'd0;
      incr_q        <= 1'b0;
      illegal_q     <= 1'b0;
      slverr_q      <= 1'b0;
      decerr_q      <= 1'b0;
      burst_count_q <= 32'd0;
      err_count_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      awready_q     <= awready_d;
      wready_q      <= wready_d;
      bvalid_q      <= bvalid_d;
      bresp_q       <= bresp_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      beat_q        <= beat_d;
      incr_q        <= incr_d;
      illegal_q     <= illegal_d;
      slverr_q      <= slverr_d;
      decerr_q      <= decerr_d;
      burst_count_q <= burst_count_d;
      err_count_q   <= err_count_d;
    end
  end

  // Byte-lane write enables.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_byte_we
      assign byte_we[gi] = mem_we && s_axi_wstrb[gi];
    end
  endgenerate

  // RAM contents are deliberately not reset.
  always_ff @(posedge axi_aclk) begin
    for (int b = 0; b < 8; b++) begin
      if (byte_we[b]) begin
        mem[mem_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // Registered readback; a same-cycle write to the same word is seen next
  // cycle (read-first).
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      rd_data_q <= 64'd0;
    end else begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign rd_data       = rd_data_q;
  assign burst_count   = burst_count_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_axi_hp_write_responder.sv
// -----------------------------------------------------------------------------
// Testbench for axi_hp_write_responder: directed vector table, hand-written
// reset / backpressure / read-first sequences, and randomized bursts checked
// against a word-array reference model of the RAM and response rules.
// -----------------------------------------------------------------------------
module tb_axi_hp_write_responder;

  localparam int          AW    = 10;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [31:0] BASE  = 32'h0000_2000;

  logic        axi_aclk = 1'b0;
  logic        axi_areset = 1'b0;
  logic [31:0] awaddr = '0;
  logic [3:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic [2:0]  awprot = '0;
  logic [3:0]  awcache = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [63:0] rd_data;
  logic [31:0] burst_count;
  logic [15:0] err_count;

  axi_hp_write_responder #(.MEM_ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .axi_aclk(axi_aclk), .axi_areset(axi_areset),
    .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awprot(awprot), .s_axi_awcache(awcache),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .burst_count(burst_count), .err_count(err_count)
  );

  always #5 axi_aclk = ~axi_aclk;

  int total = 0;
  int bad   = 0;

  logic [63:0] ref_mem [DEPTH];
  logic [63:0] beat_data [16];
  logic [7:0]  beat_strb [16];
  logic        beat_last [16];
  int unsigned touched_q [$];
  int unsigned exp_bursts = 0;
  int unsigned exp_errs   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [7:0]  strb;
    logic [63:0] seed;
    int          wlast_beat;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic tmo(input string name);
    total++;
    bad++;
    $display("FAIL %s timeout got=no_handshake expected=handshake", name);
  endtask

  // Reference model: applies the burst rules beat by beat to a word array.
  task automatic model_burst(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                             input logic [1:0] b, output logic [1:0] resp);
    bit legal, slv, dec;
    logic [31:0] ba;
    int unsigned w;
    legal = (s == 3'd3) && (b == 2'b00 || b == 2'b01);
    slv = !legal;
    dec = 1'b0;
    touched_q.delete();
    for (int i = 0; i <= int'(l); i++) begin
      ba = {a[31:3], 3'b000} + ((b == 2'b01) ? 32'(i * 8) : 32'd0);
      if (ba < BASE || ((ba - BASE) / 8) >= DEPTH) begin
        dec = 1'b1;
      end else begin
        w = (ba - BASE) / 8;
        touched_q.push_back(w);
        if (legal) begin
          for (int k = 0; k < 8; k++) begin
            if (beat_strb[i][k]) ref_mem[w][k*8 +: 8] = beat_data[i][k*8 +: 8];
          end
        end
      end
`ifdef AXI_HP_WR_LAST_CHECK_EN
      if (beat_last[i] != (i == int'(l))) slv = 1'b1;
`endif
    end
    resp = slv ? 2'b10 : (dec ? 2'b11 : 2'b00);
  endtask

  task automatic do_aw(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                       input logic [1:0] b);
    bit hs = 0;
    int t = 0;
    awaddr = a; awlen = l; awsize = s; awburst = b; awvalid = 1'b1;
    while (!hs && t < 50) begin
      @(negedge axi_aclk); hs = awready;
      @(posedge axi_aclk); #1; t++;
    end
    awvalid = 1'b0;
    if (!hs) tmo("aw_handshake");
  endtask

  task automatic do_beats(input int l, input int gap_pct);
    bit hs;
    int t, g;
    for (int i = 0; i <= l; i++) begin
      g = 0;
      while (g < 4 && $urandom_range(99) < gap_pct) begin
        wvalid = 1'b0; @(posedge axi_aclk); #1; g++;
      end
      wvalid = 1'b1; wdata = beat_data[i]; wstrb = beat_strb[i]; wlast = beat_last[i];
      hs = 0; t = 0;
      while (!hs && t < 50) begin
        @(negedge axi_aclk); hs = wready;
        @(posedge axi_aclk); #1; t++;
      end
      if (!hs) begin
        tmo("w_handshake");
        break;
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic do_b(input logic [1:0] exp, input string tag);
    bit hs = 0;
    int t = 0;
    logic [1:0] r = 2'b00;
    bready = 1'b1;
    while (!hs && t < 50) begin
      @(negedge axi_aclk); hs = bvalid; r = bresp;
      @(posedge axi_aclk); #1; t++;
    end
    bready = 1'b0;
    if (!hs) begin
      tmo({tag, "_b_handshake"});
      return;
    end
    $display("burst %s bresp=%0d expected=%0d", tag, r, exp);
    chk({tag, "_bresp"}, 64'(r), 64'(exp));
    exp_bursts++;
    if (exp != 2'b00 && exp_errs != 16'hFFFF) exp_errs++;
    chk({tag, "_burst_count"}, 64'(burst_count), 64'(exp_bursts));
    chk({tag, "_err_count"}, 64'(err_count), 64'(exp_errs));
  endtask

  task automatic check_word(input int unsigned idx, input string tag);
    rd_addr = AW'(idx);
    @(posedge axi_aclk); #1;
    chk($sformatf("%s_word%0d", tag, idx), rd_data, ref_mem[idx]);
  endtask

  task automatic run_burst(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic [1:0] exp, input string tag,
                           input int gap_pct, input int bdelay, input bit check_mem);
    do_aw(a, l, s, b);
    do_beats(int'(l), gap_pct);
    repeat (bdelay) begin @(posedge axi_aclk); #1; end
    do_b(exp, tag);
    if (check_mem) begin
      foreach (touched_q[i]) check_word(touched_q[i], tag);
    end
  endtask

  initial begin
    logic [1:0]  mresp;
    logic [63:0] old_word;
    logic [31:0] ra;
    logic [2:0]  rs;
    logic [1:0]  rb;
    logic [3:0]  rl;
    int          r;

    // Directed vectors: expected responses derived by hand.
    vecs[0]  = '{BASE + 32'h10,   4'd3,  3'd3, 2'b01, 8'hFF, 64'h1111_1111_1111_1111, 3,  2'b00};
    vecs[1]  = '{BASE + 32'h38,   4'd2,  3'd3, 2'b00, 8'hFF, 64'h0123_4567_89AB_CDEF, 2,  2'b00};
    vecs[2]  = '{BASE + 32'h38,   4'd0,  3'd3, 2'b00, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 0,  2'b00};
    vecs[3]  = '{BASE + 32'h100,  4'd1,  3'd3, 2'b10, 8'hFF, 64'h5555_5555_5555_5555, 1,  2'b10};
    vecs[4]  = '{BASE + 32'h100,  4'd1,  3'd2, 2'b01, 8'hFF, 64'h6666_6666_6666_6666, 1,  2'b10};
    vecs[5]  = '{BASE + 32'h1FF0, 4'd3,  3'd3, 2'b01, 8'hFF, 64'h7777_0000_7777_0001, 3,  2'b11};
    vecs[6]  = '{BASE - 32'h8,    4'd1,  3'd3, 2'b01, 8'hFF, 64'h0BAD_0000_0000_0101, 1,  2'b11};
    vecs[7]  = '{BASE + 32'h2000, 4'd0,  3'd3, 2'b11, 8'hFF, 64'h8888_8888_8888_8888, 0,  2'b10};
    vecs[8]  = '{BASE + 32'h320,  4'd15, 3'd3, 2'b01, 8'hA5, 64'h0102_0304_0506_0708, 15, 2'b00};
`ifdef AXI_HP_WR_LAST_CHECK_EN
    vecs[9]  = '{BASE + 32'h400,  4'd3,  3'd3, 2'b01, 8'hFF, 64'h9999_0000_0000_0009, 1,  2'b10};
`else
    vecs[9]  = '{BASE + 32'h400,  4'd3,  3'd3, 2'b01, 8'hFF, 64'h9999_0000_0000_0009, 1,  2'b00};
`endif
    vecs[10] = '{BASE + 32'h45,   4'd1,  3'd3, 2'b01, 8'hFF, 64'h0000_AAAA_0000_BBBB, 1,  2'b00};
    vecs[11] = '{BASE + 32'h2008, 4'd1,  3'd3, 2'b00, 8'hFF, 64'hCCCC_CCCC_CCCC_CCCC, 1,  2'b11};

    // Reset values.
    #3 axi_areset = 1'b1;
    repeat (3) @(posedge axi_aclk);
    #1;
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_bresp", 64'(bresp), 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_burst_count", 64'(burst_count), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    axi_areset = 1'b0;
    @(posedge axi_aclk); #1;
    chk("awready_after_reset", 64'(awready), 64'd1);

    // Fill the whole RAM with zeros so every word has a known value.
    for (int i = 0; i < 16; i++) begin
      beat_data[i] = '0; beat_strb[i] = 8'hFF; beat_last[i] = (i == 15);
    end
    for (int k = 0; k < int'(DEPTH / 16); k++) begin
      model_burst(BASE + 32'(k * 128), 4'd15, 3'd3, 2'b01, mresp);
      run_burst(BASE + 32'(k * 128), 4'd15, 3'd3, 2'b01, mresp, $sformatf("fill%0d", k), 0, 0, 1'b0);
    end

    // Reset pulse in the middle of a burst, after beat 1.
    for (int i = 0; i < 4; i++) begin
      beat_data[i] = 64'hDEAD_0000_0000_0000 + 64'(i); beat_strb[i] = 8'hFF; beat_last[i] = (i == 3);
    end
    model_burst(BASE + 32'h600, 4'd1, 3'd3, 2'b01, mresp);
    do_aw(BASE + 32'h600, 4'd3, 3'd3, 2'b01);
    do_beats(1, 0);
    axi_areset = 1'b1;
    #1;
    chk("midrst_bvalid", 64'(bvalid), 64'd0);
    chk("midrst_awready", 64'(awready), 64'd0);
    chk("midrst_wready", 64'(wready), 64'd0);
    chk("midrst_burst_count", 64'(burst_count), 64'd0);
    @(posedge axi_aclk); #1;
    chk("midrst_awready_held", 64'(awready), 64'd0);
    axi_areset = 1'b0;
    exp_bursts = 0;
    exp_errs = 0;
    @(posedge axi_aclk); #1;
    chk("postrst_awready", 64'(awready), 64'd1);
    chk("postrst_bvalid", 64'(bvalid), 64'd0);
    foreach (touched_q[i]) check_word(touched_q[i], "midrst");
    for (int i = 0; i < 4; i++) beat_data[i] = 64'hBEEF_0000_0000_0000 + 64'(i);
    model_burst(BASE + 32'h700, 4'd3, 3'd3, 2'b01, mresp);
    run_burst(BASE + 32'h700, 4'd3, 3'd3, 2'b01, 2'b00, "postrst", 0, 0, 1'b1);

    // Directed vector table.
    for (int v = 0; v < 12; v++) begin
      for (int i = 0; i < 16; i++) begin
        beat_data[i] = vecs[v].seed * 64'(i + 1);
        beat_strb[i] = vecs[v].strb;
        beat_last[i] = (i == vecs[v].wlast_beat);
      end
      model_burst(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, mresp);
      run_burst(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, vecs[v].exp_resp,
                $sformatf("vec%0d", v), 0, 1, 1'b1);
    end

    // Backpressure: bready low 5 cycles while a new AW is pending.
    beat_data[0] = 64'h1234_5678_0000_0001; beat_data[1] = 64'h1234_5678_0000_0002;
    beat_strb[0] = 8'hFF; beat_strb[1] = 8'hFF; beat_last[0] = 1'b0; beat_last[1] = 1'b1;
    model_burst(BASE + 32'h500, 4'd1, 3'd3, 2'b01, mresp);
    do_aw(BASE + 32'h500, 4'd1, 3'd3, 2'b01);
    do_beats(1, 0);
    awaddr = BASE + 32'h580; awlen = 4'd0; awvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge axi_aclk); #1;
      chk($sformatf("hold%0d_bvalid", c), 64'(bvalid), 64'd1);
      chk($sformatf("hold%0d_bresp", c), 64'(bresp), 64'(mresp));
      chk($sformatf("hold%0d_awready", c), 64'(awready), 64'd0);
    end
    awvalid = 1'b0;
    do_b(mresp, "hold");
    foreach (touched_q[i]) check_word(touched_q[i], "hold");

    // Read-first: watch word 50 while a single beat writes it.
    old_word = ref_mem[50];
    rd_addr = AW'(50);
    beat_data[0] = 64'hFACE_CAFE_0050_0050; beat_strb[0] = 8'hFF; beat_last[0] = 1'b1;
    model_burst(BASE + 32'(50 * 8), 4'd0, 3'd3, 2'b01, mresp);
    do_aw(BASE + 32'(50 * 8), 4'd0, 3'd3, 2'b01);
    do_beats(0, 0);
    chk("read_first_old", rd_data, old_word);
    @(posedge axi_aclk); #1;
    chk("read_first_new", rd_data, ref_mem[50]);
    do_b(mresp, "readfirst");

    // Randomized bursts against the model.
    for (int n = 0; n < 40; n++) begin
      ra = BASE - 32'h40 + 32'($urandom_range(DEPTH * 8 + 128));
      rl = 4'($urandom_range(15));
      rs = ($urandom_range(7) == 0) ? 3'($urandom_range(7)) : 3'd3;
      r = $urandom_range(9);
      rb = (r < 5) ? 2'b01 : ((r < 8) ? 2'b00 : 2'($urandom_range(2, 3)));
      for (int i = 0; i < 16; i++) begin
        beat_data[i] = {$urandom, $urandom};
        beat_strb[i] = 8'($urandom);
        beat_last[i] = (i == int'(rl));
      end
      if ($urandom_range(9) == 0) begin
        r = $urandom_range(int'(rl));
        beat_last[r] = ~beat_last[r];
      end
      model_burst(ra, rl, rs, rb, mresp);
      run_burst(ra, rl, rs, rb, mresp, $sformatf("rand%0d", n), 30, $urandom_range(3), 1'b1);
    end

    // Final sweep of the whole RAM against the model.
    for (int unsigned i = 0; i < DEPTH; i++) check_word(i, "sweep");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
